// File: rtl/val2_shift_sequencer_pkg.sv
// val2_shift_sequencer_pkg
//   Shared EXE-stage definitions for the iterative Val2 shifter:
//   sequencer state encoding, ARM shift-type codes and the default
//   per-cycle shift distance.
package val2_shift_sequencer_pkg;

    localparam int unsigned STEP_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Sign-extend the 12-bit load/store offset field.
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/val2_shift_sequencer_shift_step.sv
// val2_shift_sequencer_shift_step
//   Combinational single shift step of distance s (0..16).
//   Ports:
//     value     in  32  pre-step value
//     sh_type   in  2   shift type (LSL/LSR/ASR/ROR)
//     s         in  5   shift distance for this step
//     result    out 32  post-step value
//     carry_out out 1   last bit shifted out (undefined meaning when s==0)
module val2_shift_sequencer_shift_step
    import val2_shift_sequencer_pkg::*;
(
    input  logic [31:0] value,
    input  shift_type_e sh_type,
    input  logic [4:0]  s,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [32:0] lsl_ext;
    logic [32:0] lsr_ext;
    logic [32:0] asr_ext;
    logic [31:0] ror_res;

    // A guard bit above (LSL) or below (LSR/ASR) the value catches the
    // last bit shifted out without a variable-index select.
    assign lsl_ext = {1'b0, value} << s;
    assign lsr_ext = {value, 1'b0} >> s;
    assign asr_ext = $signed({value, 1'b0}) >>> s;
    assign ror_res = (value >> s) | (value << (6'd32 - {1'b0, s}));

    always_comb begin
        result    = value;
        carry_out = 1'b0;
        unique case (sh_type)
            SH_LSL: begin
                result    = lsl_ext[31:0];
                carry_out = lsl_ext[32];
            end
            SH_LSR: begin
                result    = lsr_ext[32:1];
                carry_out = lsr_ext[0];
            end
            SH_ASR: begin
                result    = asr_ext[32:1];
                carry_out = asr_ext[0];
            end
            SH_ROR: begin
                result    = ror_res;
                carry_out = ror_res[31];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/val2_shift_sequencer.sv
// val2_shift_sequencer
//   Multi-cycle generator of the EXE-stage ALU operand Val2 and the
//   shifter carry-out. Shifts at most STEP_BITS positions per cycle.
//   Ports:
//     clk           in  1   clock, rising edge
//     rst           in  1   synchronous active-high reset
//     start         in  1   job request, sampled only in IDLE
//     Val_Rm        in  32  register operand Rm
//     imm           in  1   rotated immed_8 form
//     selmem        in  1   load/store offset form (priority over imm)
//     Shift_operand in  12  instruction bits [11:0]
//     carry_in      in  1   current CPSR C flag
//     busy          out 1   high while shifting
//     done          out 1   one-cycle result-valid pulse
//     Val2          out 32  result, held until next done
//     shift_carry   out 1   shifter carry-out, held with Val2
module val2_shift_sequencer
    import val2_shift_sequencer_pkg::*;
#(
    parameter int unsigned STEP_BITS = STEP_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic        selmem,
    input  logic [11:0] Shift_operand,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] Val2,
    output logic        shift_carry
);

    localparam logic [4:0] STEP_W = 5'(STEP_BITS);

    seq_state_e  state_q, state_d;
    logic [31:0] work_q,  work_d;
    shift_type_e type_q,  type_d;
    logic [4:0]  rem_q,   rem_d;
    logic [31:0] val2_q,  val2_d;
    logic        carry_q, carry_d;

    logic [4:0]  step;
    logic [31:0] step_res;
    logic        step_carry;

    logic [31:0] cap_op;
    shift_type_e cap_type;
    logic [4:0]  cap_amt;

    assign step = (rem_q > STEP_W) ? STEP_W : rem_q;

    val2_shift_sequencer_shift_step u_step (
        .value     (work_q),
        .sh_type   (type_q),
        .s         (step),
        .result    (step_res),
        .carry_out (step_carry)
    );

    // Decode of the job presented on the inputs (non-memory forms).
    always_comb begin
        if (imm) begin
            cap_op   = {24'd0, Shift_operand[7:0]};
            cap_type = SH_ROR;
            cap_amt  = {Shift_operand[11:8], 1'b0};
        end else begin
            cap_op   = Val_Rm;
            cap_type = shift_type_e'(Shift_operand[6:5]);
            cap_amt  = Shift_operand[11:7];
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        type_d  = type_q;
        rem_d   = rem_q;
        val2_d  = val2_q;
        carry_d = carry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (selmem) begin
                        val2_d  = sext12(Shift_operand);
                        carry_d = carry_in;
                        state_d = ST_DONE;
                    end else if (cap_amt == 5'd0) begin
                        val2_d  = cap_op;
                        carry_d = carry_in;
                        state_d = ST_DONE;
                    end else begin
                        work_d  = cap_op;
                        type_d  = cap_type;
                        rem_d   = cap_amt;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_res;
                rem_d  = rem_q - step;
                if (rem_d == 5'd0) begin
                    val2_d  = step_res;
                    carry_d = step_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            type_q  <= SH_LSL;
            rem_q   <= '0;
            val2_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            type_q  <= type_d;
            rem_q   <= rem_d;
            val2_q  <= val2_d;
            carry_q <= carry_d;
        end
    end

    assign busy        = (state_q == ST_SHIFT);
    assign done        = (state_q == ST_DONE);
    assign Val2        = val2_q;
    assign shift_carry = carry_q;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
module tb_val2_shift_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] Val_Rm = '0;
    logic        imm = 1'b0;
    logic        selmem = 1'b0;
    logic [11:0] Shift_operand = '0;
    logic        carry_in = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] Val2;
    logic        shift_carry;

    int checks = 0;
    int errors = 0;

    val2_shift_sequencer #(.STEP_BITS(STEP)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .Val_Rm        (Val_Rm),
        .imm           (imm),
        .selmem        (selmem),
        .Shift_operand (Shift_operand),
        .carry_in      (carry_in),
        .busy          (busy),
        .done          (done),
        .Val2          (Val2),
        .shift_carry   (shift_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Whole-distance ARM shift computed in one go; returns {carry, value}.
    function automatic logic [32:0] model(input logic [31:0] rm, input logic im, input logic sel,
                                          input logic [11:0] so, input logic cin, output int lat);
        logic [31:0] op, v;
        logic        c;
        int          n, t;
        if (sel) begin
            lat = 1;
            return {cin, {{20{so[11]}}, so}};
        end
        if (im) begin
            op = {24'd0, so[7:0]};
            t  = 3;
            n  = 2 * int'(so[11:8]);
        end else begin
            op = rm;
            t  = int'(so[6:5]);
            n  = int'(so[11:7]);
        end
        if (n == 0) begin
            lat = 1;
            return {cin, op};
        end
        lat = 1 + (n + STEP - 1) / STEP;
        case (t)
            0: begin v = op << n;              c = op[32-n]; end
            1: begin v = op >> n;              c = op[n-1];  end
            2: begin v = $signed(op) >>> n;    c = op[n-1];  end
            default: begin v = (op >> n) | (op << (32 - n)); c = v[31]; end
        endcase
        return {c, v};
    endfunction

    // Issue one job, hold start until done, verify busy/done timing and result.
    // With scramble set, inputs and start wiggle after capture and must be ignored.
    task automatic run_job(input logic [31:0] rm, input logic im, input logic sel,
                           input logic [11:0] so, input logic cin, input bit scramble);
        logic [32:0] exp;
        int          lat;
        exp = model(rm, im, sel, so, cin, lat);
        @(negedge clk);
        Val_Rm = rm; imm = im; selmem = sel; Shift_operand = so; carry_in = cin;
        start = 1'b1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                Val_Rm = $urandom; Shift_operand = 12'($urandom);
                imm = 1'($urandom); selmem = 1'($urandom); carry_in = 1'($urandom);
                start = 1'($urandom);
            end
            if (cyc < lat) begin
                check("busy/done while shifting", {30'd0, busy, done}, 32'b10);
            end else begin
                start = 1'b0;
                check("busy/done at result", {30'd0, busy, done}, 32'b01);
                check("Val2", Val2, exp[31:0]);
                check("shift_carry", {31'd0, shift_carry}, {31'd0, exp[32]});
            end
        end
        @(posedge clk);
        #1;
        check("done single pulse", {30'd0, busy, done}, 32'b00);
        check("Val2 held", Val2, exp[31:0]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset ctl", {30'd0, busy, done}, 32'b00);
        check("reset Val2", Val2, 32'h0);
        check("reset carry", {31'd0, shift_carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_job(32'h000000F1, 1'b0, 1'b0, 12'h200, 1'b1, 1'b0);   // LSL #4
        run_job(32'h80000000, 1'b0, 1'b0, 12'hFC0, 1'b1, 1'b0);   // ASR #31
        run_job(32'h0,        1'b1, 1'b0, 12'h4FF, 1'b0, 1'b0);   // imm ror 8
        run_job(32'h0,        1'b1, 1'b1, 12'hFFC, 1'b0, 1'b0);   // selmem priority
        run_job(32'h12345678, 1'b0, 1'b0, 12'h060, 1'b1, 1'b0);   // ROR #0
        run_job(32'h80000001, 1'b0, 1'b0, 12'hFA0, 1'b0, 1'b0);   // LSR #31
        run_job(32'h80000001, 1'b0, 1'b0, 12'h080, 1'b0, 1'b0);   // LSL #1
        run_job(32'h0000000F, 1'b0, 1'b0, 12'h2E0, 1'b0, 1'b1);   // ROR #5, start/input noise

        // Reset in the 3rd SHIFT cycle discards the job
        @(negedge clk);
        Val_Rm = 32'h80000000; imm = 1'b0; selmem = 1'b0; Shift_operand = 12'hFC0; carry_in = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort ctl", {30'd0, busy, done}, 32'b00);
        check("abort Val2", Val2, 32'h0);
        check("abort carry", {31'd0, shift_carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("idle after abort", {30'd0, busy, done}, 32'b00);
        end
        run_job(32'hDEADBEEF, 1'b0, 1'b0, 12'h540, 1'b1, 1'b0);  // ASR #10

        // Randomized jobs
        for (int k = 0; k < 300; k++) begin
            logic [11:0] so;
            logic sel, im;
            so  = 12'($urandom);
            sel = ($urandom_range(0, 7) == 0);
            im  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) so[11:7] = 5'd0;
            run_job($urandom, im, sel, so, 1'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/val2_shift_sequencer.md
Name: val2_shift_sequencer

Overview:
- Multi-cycle controller that produces the EXE-stage second ALU operand (Val2) and the ARM shifter carry-out.
- Replaces a full single-cycle barrel shifter with an iterative shift of at most STEP_BITS per cycle.
- Sits in EXE between ID/EXE register outputs and the ALU B-input. Drives busy to the hazard/stall unit so the pipeline holds while a shift is in progress.

Parameters:
- STEP_BITS, 4, maximum shift distance per cycle; power of two, 1..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- Val_Rm  in  32  register operand Rm
- imm  in  1  immediate (rotated immed_8) form
- selmem  in  1  load/store offset form; priority over imm
- Shift_operand  in  12  instruction bits [11:0]
- carry_in  in  1  current CPSR C flag
- busy  out  1  high while in SHIFT state
- done  out  1  one-cycle pulse; Val2/shift_carry valid
- Val2  out  32  result; held until next done
- shift_carry  out  1  shifter carry-out; held with Val2

Behaviour:
- One clock; reset is synchronous and active-high. rst forces state IDLE, Val2=0, shift_carry=0, busy=0, done=0, remaining count=0. This applies from any state, including mid-SHIFT; the aborted result is discarded.
- States: IDLE, SHIFT, DONE.
- In IDLE, start=1 captures the job on that edge:
  - selmem=1: Val2 = sign-extend(Shift_operand[11:0]), shift_carry = carry_in, next state DONE.
  - else imm=1: operand = zero-extended Shift_operand[7:0], type = ROR, amount = 2*Shift_operand[11:8] (0..30).
  - else: operand = Val_Rm, type = Shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), amount = Shift_operand[11:7] (0..31).
  - If amount==0: Val2 = operand, shift_carry = carry_in, next state DONE. Amount 0 means no shift; the ARM LSR/ASR #32 and RRX encodings are not supported.
  - Else: working register = operand, remaining = amount, next state SHIFT.
- In SHIFT, each cycle:
  - s = min(remaining, STEP_BITS).
  - Working register shifted by s using the captured type. ASR replicates bit 31; ROR rotates within 32 bits.
  - Carry is the last bit shifted out of the pre-step value:
    - LSL: bit[32-s]
    - LSR/ASR: bit[s-1]
    - ROR: post-step bit[31]
  - remaining -= s. When remaining reaches 0: Val2 ← result, shift_carry ← carry, next state DONE.
- In DONE: done=1 for exactly one cycle, then IDLE. A start in that cycle is ignored.
- start while in SHIFT or DONE is ignored. The requester must hold start until it sees done.
- Latency from the start edge:
  - selmem or amount 0: done in the next cycle (1).
  - Otherwise: 1 + ceil(amount/STEP_BITS). Worst case with STEP_BITS=4 is 9 cycles (amount 31).
- busy = (state==SHIFT). done is combinational from state only; no input-to-output combinational paths.

Decomposition:
- Shared EXE package holds:
  - state encoding (IDLE/SHIFT/DONE)
  - shift-type constants LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11
  - STEP_BITS default.
- One natural sub-module, shift_step: combinational single step. Inputs: value[31:0], type, s. Outputs: result[31:0], carry_out. The sequencer holds the FSM, counter and registers.

Test Plan:
- LSL: Val_Rm=0x000000F1, Shift_operand=0x200 (amount 4, LSL) -> done at cycle 2, Val2=0x00000F10, shift_carry=0.
- ASR max: Val_Rm=0x80000000, Shift_operand=0xFC0 (amount 31, ASR) -> busy for 8 cycles, done at cycle 9, Val2=0xFFFFFFFF, shift_carry=0.
- Immediate: imm=1, Shift_operand=0x4FF (rotate 8) -> done at cycle 3, Val2=0xFF000000, shift_carry=1.
- Memory offset: selmem=1, imm=1, Shift_operand=0xFFC -> done at cycle 1, Val2=0xFFFFFFFC; selmem priority confirmed.
- Zero amount: Val_Rm=0x12345678, Shift_operand=0x060 (ROR #0), carry_in=1 -> done at cycle 1, Val2=0x12345678, shift_carry=1.
- Control:
  - start pulsed during SHIFT is ignored; result matches the first job.
  - rst asserted at 3rd SHIFT cycle -> next cycle IDLE, busy=0, done=0, Val2=0; a following job completes normally.
